// File: rtl/stk_mem_pkg.sv
// Shared definitions for the stack/memory transfer engine.
//  - Opcode encodings presented on opc when a command is started.
//  - FSM state encoding used by stk_mem_xfer.
package stk_mem_pkg;

    localparam logic [1:0] OP_PUSHC = 2'b00;  // constant -> stack
    localparam logic [1:0] OP_PUSHM = 2'b01;  // mem[addr..] -> stack
    localparam logic [1:0] OP_POPM  = 2'b10;  // stack -> mem[addr..]
    localparam logic [1:0] OP_RSVD  = 2'b11;  // reserved, completes with err

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_WAIT = 3'd2,
        S_PUSH    = 3'd3,
        S_POP     = 3'd4,
        S_POP_W   = 3'd5,
        S_WR      = 3'd6,
        S_DONE    = 3'd7
    } xfer_state_t;

endpackage

// File: rtl/xfer_addr_gen.sv
// Burst address generator for stk_mem_xfer.
// Loads the base address and word count when a command is accepted and
// steps once per transferred word. PUSHM walks upward from base; POPM walks
// downward from base+count-1, so a POPM over the range a PUSHM filled puts
// every word back where it came from. Address arithmetic wraps modulo
// 2**ADDR_LEN.
// Ports:
//  clk, rstn  clock and asynchronous active-low reset
//  load       capture opc/base/count (command accepted)
//  step       advance to the next word
//  opc        command opcode, selects direction
//  base       base address
//  count      number of words in the burst
//  addr       address of the current word
//  last       current word is the final one of the burst
module xfer_addr_gen
    import stk_mem_pkg::*;
#(
    parameter int ADDR_LEN = 8,
    parameter int CNT_LEN  = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                load,
    input  logic                step,
    input  logic [1:0]          opc,
    input  logic [ADDR_LEN-1:0] base,
    input  logic [CNT_LEN-1:0]  count,
    output logic [ADDR_LEN-1:0] addr,
    output logic                last
);

    logic [CNT_LEN-1:0] remaining;
    logic               down;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr      <= '0;
            remaining <= '0;
            down      <= 1'b0;
        end else if (load) begin
            down      <= (opc == OP_POPM);
            remaining <= count;
            // POPM starts at the top of the range (count is zero-extended).
            if (opc == OP_POPM)
                addr <= base + ADDR_LEN'(count) - ADDR_LEN'(1);
            else
                addr <= base;
        end else if (step) begin
            remaining <= remaining - CNT_LEN'(1);
            if (down)
                addr <= addr - ADDR_LEN'(1);
            else
                addr <= addr + ADDR_LEN'(1);
        end
    end

    assign last = (remaining == CNT_LEN'(1));

endmodule

// File: rtl/stk_mem_xfer.sv
// Multi-word transfer engine between the operand stack and data memory.
// Executes PUSHC (constant -> stack), PUSHM (mem[addr..] -> stack) and
// POPM (stack -> mem[addr..]) bursts, with configurable memory read latency
// and stack overflow/underflow detection reported through err.
// Ports:
//  clk, rstn      clock and asynchronous active-low reset
//  en             command start strobe, sampled only when idle
//  opc            00 PUSHC, 01 PUSHM, 10 POPM, 11 reserved
//  addr_const     base address, or constant for PUSHC
//  count          burst length for PUSHM/POPM
//  stk_data_in    word to push (valid with stk_push)
//  stk_push       push strobe
//  stk_pop        pop strobe (stk_data_out valid the next cycle)
//  stk_data_out   stack top
//  stk_full       stack cannot accept a push
//  stk_empty      stack has nothing to pop
//  mem_data_in    write data (valid with mem_w_en)
//  mem_addr       memory address (valid with mem_r_en / mem_w_en)
//  mem_r_en       read strobe
//  mem_w_en       write strobe
//  mem_data_out   read data, MEM_RD_LAT cycles after mem_r_en
//  busy           engine is executing a command
//  fin_sig        one-cycle completion pulse
//  err            command aborted or reserved; held until next command
module stk_mem_xfer
    import stk_mem_pkg::*;
#(
    parameter int ADDR_LEN   = 8,
    parameter int DATA_LEN   = 8,
    parameter int CNT_LEN    = 4,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic [1:0]          opc,
    input  logic [ADDR_LEN-1:0] addr_const,
    input  logic [CNT_LEN-1:0]  count,
    output logic [DATA_LEN-1:0] stk_data_in,
    output logic                stk_push,
    output logic                stk_pop,
    input  logic [DATA_LEN-1:0] stk_data_out,
    input  logic                stk_full,
    input  logic                stk_empty,
    output logic [DATA_LEN-1:0] mem_data_in,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_r_en,
    output logic                mem_w_en,
    input  logic [DATA_LEN-1:0] mem_data_out,
    output logic                busy,
    output logic                fin_sig,
    output logic                err
);

    localparam int LAT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

    xfer_state_t        state, next_state;
    logic [1:0]         op_q;
    logic [LAT_W-1:0]   lat_cnt;
    logic               lat_last;
    logic               last_word;

    logic               load_cmd;
    logic               load_const;
    logic               cap_rd;
    logic               cap_pop;
    logic               set_err;
    logic               step;

    xfer_addr_gen #(
        .ADDR_LEN (ADDR_LEN),
        .CNT_LEN  (CNT_LEN)
    ) u_addr_gen (
        .clk   (clk),
        .rstn  (rstn),
        .load  (load_cmd),
        .step  (step),
        .opc   (opc),
        .base  (addr_const),
        .count (count),
        .addr  (mem_addr),
        .last  (last_word)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Overflow/underflow are detected on the transition into PUSH/POP, so
    // those states are only ever entered when the strobe is legal.
    always_comb begin
        next_state = state;
        load_cmd   = 1'b0;
        load_const = 1'b0;
        cap_rd     = 1'b0;
        cap_pop    = 1'b0;
        set_err    = 1'b0;
        step       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (en) begin
                    load_cmd = 1'b1;
                    case (opc)
                        OP_PUSHC: begin
                            load_const = 1'b1;
                            if (stk_full) begin
                                next_state = S_DONE;
                                set_err    = 1'b1;
                            end else begin
                                next_state = S_PUSH;
                            end
                        end
                        OP_PUSHM: begin
                            next_state = (count == '0) ? S_DONE : S_RD;
                        end
                        OP_POPM: begin
                            if (count == '0) begin
                                next_state = S_DONE;
                            end else if (stk_empty) begin
                                next_state = S_DONE;
                                set_err    = 1'b1;
                            end else begin
                                next_state = S_POP;
                            end
                        end
                        OP_RSVD: begin
                            next_state = S_DONE;
                            set_err    = 1'b1;
                        end
                    endcase
                end
            end
            S_RD: begin
                next_state = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_last) begin
                    if (stk_full) begin
                        next_state = S_DONE;
                        set_err    = 1'b1;
                    end else begin
                        next_state = S_PUSH;
                        cap_rd     = 1'b1;
                    end
                end
            end
            S_PUSH: begin
                if (op_q == OP_PUSHC) begin
                    next_state = S_DONE;
                end else begin
                    step       = 1'b1;
                    next_state = last_word ? S_DONE : S_RD;
                end
            end
            S_POP: begin
                next_state = S_POP_W;
            end
            S_POP_W: begin
                next_state = S_WR;
                cap_pop    = 1'b1;
            end
            S_WR: begin
                step = 1'b1;
                if (last_word) begin
                    next_state = S_DONE;
                end else if (stk_empty) begin
                    next_state = S_DONE;
                    set_err    = 1'b1;
                end else begin
                    next_state = S_POP;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Read-latency counter: cleared in RD, counts through RD_WAIT; the read
    // data is captured on the final RD_WAIT cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            lat_cnt <= '0;
        else if (state == S_RD)
            lat_cnt <= '0;
        else if (state == S_RD_WAIT && !lat_last)
            lat_cnt <= lat_cnt + LAT_W'(1);
    end

    assign lat_last = (lat_cnt == LAT_W'(MEM_RD_LAT - 1));

    // Datapath registers; set_err wins over the clear so a reserved opcode
    // reports err in the same DONE cycle it was accepted for.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q        <= OP_PUSHC;
            stk_data_in <= '0;
            mem_data_in <= '0;
            err         <= 1'b0;
        end else begin
            if (load_cmd)
                op_q <= opc;
            if (load_const)
                stk_data_in <= DATA_LEN'(addr_const);
            else if (cap_rd)
                stk_data_in <= mem_data_out;
            if (cap_pop)
                mem_data_in <= stk_data_out;
            if (set_err)
                err <= 1'b1;
            else if (load_cmd)
                err <= 1'b0;
        end
    end

    // Strobes decode straight from the state register, so they carry no
    // combinational path from the inputs and are mutually exclusive.
    assign stk_push = (state == S_PUSH);
    assign stk_pop  = (state == S_POP);
    assign mem_r_en = (state == S_RD);
    assign mem_w_en = (state == S_WR);
    assign busy     = (state != S_IDLE);
    assign fin_sig  = (state == S_DONE);

endmodule

// File: tb/tb_stk_mem_xfer.sv
// Self-checking bench for stk_mem_xfer with a behavioural stack and
// memory. Expected pushes, reads and writes are queued when a command is
// issued and consumed as the DUT strobes appear.
module tb_stk_mem_xfer;
    import stk_mem_pkg::*;

    localparam int ADDR_LEN   = 8;
    localparam int DATA_LEN   = 8;
    localparam int CNT_LEN    = 4;
    localparam int MEM_RD_LAT = 1;

    logic                clk = 1'b0;
    logic                rstn;
    logic                en;
    logic [1:0]          opc;
    logic [ADDR_LEN-1:0] addr_const;
    logic [CNT_LEN-1:0]  count;
    logic [DATA_LEN-1:0] stk_data_in;
    logic                stk_push;
    logic                stk_pop;
    logic [DATA_LEN-1:0] stk_data_out;
    logic                stk_full;
    logic                stk_empty;
    logic [DATA_LEN-1:0] mem_data_in;
    logic [ADDR_LEN-1:0] mem_addr;
    logic                mem_r_en;
    logic                mem_w_en;
    logic [DATA_LEN-1:0] mem_data_out;
    logic                busy;
    logic                fin_sig;
    logic                err;

    stk_mem_xfer #(
        .ADDR_LEN   (ADDR_LEN),
        .DATA_LEN   (DATA_LEN),
        .CNT_LEN    (CNT_LEN),
        .MEM_RD_LAT (MEM_RD_LAT)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en           (en),
        .opc          (opc),
        .addr_const   (addr_const),
        .count        (count),
        .stk_data_in  (stk_data_in),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_out (stk_data_out),
        .stk_full     (stk_full),
        .stk_empty    (stk_empty),
        .mem_data_in  (mem_data_in),
        .mem_addr     (mem_addr),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .mem_data_out (mem_data_out),
        .busy         (busy),
        .fin_sig      (fin_sig),
        .err          (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0]  mem [256];
    logic [7:0]  stack [32];
    int          sp = 0;
    int          full_lim = 16;
    logic [7:0]  exp_push [$];
    logic [7:0]  exp_rd [$];
    logic [15:0] exp_wr [$];
    logic        rd_pend = 1'b0;
    logic [7:0]  rd_pend_addr = '0;
    logic        pop_pend = 1'b0;
    logic [7:0]  pop_val = '0;
    logic        fin_seen = 1'b0;
    int          fin_cnt = 0;
    int          fin_cyc = 0;
    int          acc_cyc = 0;
    int          pops = 0;
    logic        exp_err = 1'b0;
    int          fin_before = 0;
    int          pops_before = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic monitor();
        logic [15:0] w;
        if (busy)
            checkOutput("strobe_onehot",
                        32'($countones({stk_push, stk_pop, mem_r_en, mem_w_en}) <= 1), 1);
        if (rd_pend) begin
            mem_data_out = mem[rd_pend_addr];
            rd_pend = 1'b0;
        end
        if (pop_pend) begin
            stk_data_out = pop_val;
            pop_pend = 1'b0;
        end
        if (mem_r_en) begin
            checkOutput("rd_expected", 32'(exp_rd.size() != 0), 1);
            if (exp_rd.size() != 0)
                checkOutput("rd_addr", mem_addr, exp_rd.pop_front());
            rd_pend = 1'b1;
            rd_pend_addr = mem_addr;
        end
        if (stk_pop) begin
            pops++;
            checkOutput("pop_nonempty", 32'(sp != 0), 1);
            if (sp > 0) begin
                sp--;
                pop_val = stack[sp];
                pop_pend = 1'b1;
            end
        end
        if (stk_push) begin
            checkOutput("push_expected", 32'(exp_push.size() != 0), 1);
            if (exp_push.size() != 0)
                checkOutput("push_data", stk_data_in, exp_push.pop_front());
            if (sp < 32) begin
                stack[sp] = stk_data_in;
                sp++;
            end
        end
        if (mem_w_en) begin
            checkOutput("wr_expected", 32'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                checkOutput("wr_addr", mem_addr, w[15:8]);
                checkOutput("wr_data", mem_data_in, w[7:0]);
            end
            mem[mem_addr] = mem_data_in;
        end
        stk_full  = (sp >= full_lim);
        stk_empty = (sp == 0);
        if (fin_sig) begin
            fin_seen = 1'b1;
            fin_cnt++;
            fin_cyc = cyc;
            checkOutput("fin_err", err, exp_err);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] ac,
                                 input logic [3:0] cnt, input logic e_err);
        opc = op;
        addr_const = ac;
        count = cnt;
        exp_err = e_err;
        fin_seen = 1'b0;
        acc_cyc = cyc;
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic waitFin(input string tag, input int exp_lat);
        int n = 0;
        while (!fin_seen && n < 60) begin
            tick();
            n++;
        end
        checkOutput({tag, ":fin"}, 32'(fin_seen), 1);
        if (fin_seen)
            checkOutput({tag, ":latency"}, fin_cyc - acc_cyc, exp_lat);
        tick();
        checkOutput({tag, ":idle"}, busy, 0);
        checkOutput({tag, ":queues"}, exp_rd.size() + exp_push.size() + exp_wr.size(), 0);
    endtask

    initial begin
        rstn = 1'b0;
        en = 1'b0;
        opc = OP_PUSHC;
        addr_const = '0;
        count = '0;
        stk_data_out = '0;
        mem_data_out = '0;
        stk_full = 1'b0;
        stk_empty = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3;
        mem[8'h20] = 8'hD4; mem[8'h21] = 8'hE5; mem[8'h22] = 8'hF6; mem[8'h23] = 8'h07;

        $display("[TB] reset");
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {busy, fin_sig, err, stk_push, stk_pop, mem_r_en,
                                      mem_w_en, stk_data_in, mem_data_in, mem_addr}, 0);
        rstn = 1'b1;
        tick();

        $display("[TB] PUSHC 0x2A");
        exp_push.push_back(8'h2A);
        applyStimulus(OP_PUSHC, 8'h2A, 4'd0, 1'b0);
        checkOutput("pushc_strobe_c1", stk_push, 1);
        waitFin("pushc", 2);

        $display("[TB] PUSHM base=0x10 count=3");
        exp_rd.push_back(8'h10); exp_rd.push_back(8'h11); exp_rd.push_back(8'h12);
        exp_push.push_back(8'hA1); exp_push.push_back(8'hB2); exp_push.push_back(8'hC3);
        applyStimulus(OP_PUSHM, 8'h10, 4'd3, 1'b0);
        checkOutput("pushm_rd_c1", mem_r_en, 1);
        waitFin("pushm", 10);

        $display("[TB] POPM base=0xFE count=3 (wrap)");
        exp_wr.push_back({8'h00, 8'hC3});
        exp_wr.push_back({8'hFF, 8'hB2});
        exp_wr.push_back({8'hFE, 8'hA1});
        applyStimulus(OP_POPM, 8'hFE, 4'd3, 1'b0);
        waitFin("popm_wrap", 10);

        $display("[TB] PUSHM count=4 with overflow after 2 pushes");
        full_lim = sp + 2;
        exp_rd.push_back(8'h20); exp_rd.push_back(8'h21); exp_rd.push_back(8'h22);
        exp_push.push_back(8'hD4); exp_push.push_back(8'hE5);
        applyStimulus(OP_PUSHM, 8'h20, 4'd4, 1'b1);
        waitFin("overflow", 9);
        full_lim = 16;
        stk_full = 1'b0;

        $display("[TB] POPM base=0x40 count=3 drains the stack");
        exp_wr.push_back({8'h42, 8'hE5});
        exp_wr.push_back({8'h41, 8'hD4});
        exp_wr.push_back({8'h40, 8'h2A});
        applyStimulus(OP_POPM, 8'h40, 4'd3, 1'b0);
        waitFin("popm_drain", 10);

        $display("[TB] POPM count=2 on empty stack");
        pops_before = pops;
        applyStimulus(OP_POPM, 8'h50, 4'd2, 1'b1);
        waitFin("underflow_empty", 1);
        checkOutput("underflow_no_pop", pops - pops_before, 0);

        $display("[TB] POPM count=2 with one word on the stack");
        exp_push.push_back(8'h33);
        applyStimulus(OP_PUSHC, 8'h33, 4'd0, 1'b0);
        waitFin("pushc_33", 2);
        exp_wr.push_back({8'h61, 8'h33});
        applyStimulus(OP_POPM, 8'h60, 4'd2, 1'b1);
        waitFin("underflow_mid", 4);

        $display("[TB] PUSHM count=0");
        applyStimulus(OP_PUSHM, 8'h10, 4'd0, 1'b0);
        waitFin("count_zero", 1);

        $display("[TB] reserved opcode");
        applyStimulus(OP_RSVD, 8'h10, 4'd2, 1'b1);
        waitFin("reserved", 1);
        repeat (3) tick();
        checkOutput("err_held", err, 1);

        $display("[TB] reset during PUSHM RD_WAIT");
        exp_rd.push_back(8'h10); exp_rd.push_back(8'h11);
        exp_push.push_back(8'hA1); exp_push.push_back(8'hB2);
        applyStimulus(OP_PUSHM, 8'h10, 4'd2, 1'b0);
        checkOutput("err_cleared_on_accept", err, 0);
        tick();
        checkOutput("rst_pre_busy", busy, 1);
        fin_before = fin_cnt;
        rstn = 1'b0;
        #1;
        checkOutput("rst_all_zero", {busy, fin_sig, err, stk_push, stk_pop, mem_r_en,
                                     mem_w_en, stk_data_in, mem_data_in, mem_addr}, 0);
        exp_rd.delete();
        exp_push.delete();
        rd_pend = 1'b0;
        tick();
        rstn = 1'b1;
        repeat (8) tick();
        checkOutput("rst_no_fin", fin_cnt - fin_before, 0);
        checkOutput("rst_idle", busy, 0);

        $display("[TB] en while busy is ignored");
        fin_before = fin_cnt;
        exp_rd.push_back(8'h10);
        exp_push.push_back(8'hA1);
        applyStimulus(OP_PUSHM, 8'h10, 4'd1, 1'b0);
        opc = OP_PUSHC;
        addr_const = 8'h77;
        en = 1'b1;
        tick();
        en = 1'b0;
        waitFin("busy_en", 4);
        repeat (6) tick();
        checkOutput("busy_en_one_fin", fin_cnt - fin_before, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
